ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Bus initiator for the single-port word RAM. Takes a byte stream (e.g. from a UART receiver),
//  assembles little-endian 32-bit words and writes them to RAM at byte addresses 0,4,8,...
//  Re-reads every word to check the checksum, then releases the CPU reset.
//  Sits between the host link and the RAM port; muxed with the CPU RAM port, owning it while busy.
// PARAMETERS
//  DEPTH_WORDS  32  max words accepted (RAM holds 128 byte-address entries = 32 words at stride 4)
//  RD_LATENCY   1   clocks from ram_a driven to ram_rd valid (RAM registers rd on posedge)
// PORTS
//  clk          in   1   clock
//  resetn       in   1   async active-low reset
//  start        in   1   1-cycle pulse: begin a load (ignored unless state IDLE/DONE/ERROR)
//  in_valid     in   1   byte available on in_data
//  in_data      in   8   stream byte
//  in_ready     out  1   loader accepts byte this cycle (transfer = in_valid & in_ready)
//  ram_we       out  1   RAM write enable, 1-cycle pulse per word
//  ram_a        out  32  RAM byte address (always multiple of 4)
//  ram_wd       out  32  RAM write data
//  ram_rd       in   32  RAM read data
//  cpu_resetn   out  1   CPU reset, active-low; 1 only in DONE
//  busy         out  1   state not IDLE/DONE/ERROR
//  done         out  1   load + verify passed (level, held until next start)
//  error        out  1   length or verify failure (level, held until next start)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0, ram_we=0, ram_a=0, ram_wd=0, cpu_resetn=0, busy=0, done=0, error=0.
//  Reset asserted at any point aborts immediately; RAM contents are left as-is.
//  Stream format: LEN[7:0], LEN[15:8], then LEN words, 4 bytes each, LSB first. No trailer.
//  States:
//   IDLE   -start-> LEN0; cpu_resetn=0, done/error cleared, word count/checksum/index cleared
//   LEN0   in_ready=1; on transfer latch len[7:0] -> LEN1
//   LEN1   in_ready=1; on transfer latch len[15:8]; len==0 -> DONE; len>DEPTH_WORDS -> ERROR; else -> DATA
//   DATA   in_ready=1; collect bytes 0..3 into word; 4th transfer -> WRITE
//   WRITE  in_ready=0; ram_we=1 one cycle, ram_a=idx*4, ram_wd=word; sum+=word (mod 2^32);
//          idx++; idx==len -> VADDR (idx=0, vsum=0), else -> DATA
//   VADDR  ram_we=0, ram_a=idx*4 -> VWAIT
//   VWAIT  hold ram_a RD_LATENCY cycles -> VSAMP
//   VSAMP  vsum+=ram_rd; idx++; idx==len -> CHECK else -> VADDR
//   CHECK  vsum==sum -> DONE else -> ERROR
//   DONE   cpu_resetn=1, done=1; start -> LEN0 (cpu_resetn drops to 0 the cycle after start)
//   ERROR  error=1, cpu_resetn=0; start -> LEN0
//  in_ready is a registered state decode; no byte is taken outside LEN0/LEN1/DATA.
//  in_valid gaps are allowed anywhere; partial word is held indefinitely.
//  ram_we never asserted outside WRITE; at most DEPTH_WORDS writes per load.
//  On length error no RAM write occurs. start during busy states is ignored.
//  Index width 16 bits; address = {idx,2'b00} zero-extended to 32; checksum 32-bit wrap-around.
//  Throughput: 1 byte/cycle into DATA, +1 cycle per word for WRITE. Verify is 2+RD_LATENCY cycles/word.
// TESTING
//  1. Load LEN=11 with the toggle program (00000293,00000313,...,fd9ff06f) over a RAM model ->
//     11 we pulses at a=0x00..0x28, correct wd; verify passes; done=1, cpu_resetn=1, error=0.
//  2. LEN=0 (bytes 00 00) -> no ram_we, DONE next cycle, cpu_resetn=1.
//  3. LEN=33 (bytes 21 00) -> ERROR, error=1, zero ram_we, in_ready=0 afterwards, cpu_resetn=0.
//  4. LEN=2; bench flips bit 0 of ram_rd during verify of word 1 -> ERROR, done=0.
//  5. LEN=3 with random in_valid gaps (1-5 cycles) -> identical writes to gap-free run; no extra bytes taken.
//  6. resetn low after 6 data bytes, then start with LEN=1 -> prior partial word discarded,
//     single write to a=0 with the new word; DONE. Also start pulse in DATA -> ignored.

Source files
------------

// File: rtl/ram_loader_if.sv
// Byte-stream sink and word-RAM initiator bundle for the loader.
// master is the loader's view; slave is the host link / RAM side.
interface ram_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_we;
  logic [31:0] ram_a;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  modport master (
    input  in_valid, in_data, ram_rd,
    output in_ready, ram_we, ram_a, ram_wd
  );

  modport slave (
    output in_valid, in_data, ram_rd,
    input  in_ready, ram_we, ram_a, ram_wd
  );
endinterface

// File: rtl/ram_loader.sv
// Loads a length-prefixed little-endian word stream into RAM, re-reads it to
// verify the checksum, and releases the CPU reset on success.
module ram_loader #(
  parameter int DEPTH_WORDS = 32,
  parameter int RD_LATENCY  = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  ram_loader_if.master  bus,
  output logic          cpu_resetn,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, VADDR, VWAIT, VSAMP, CHECK, DONE, ERROR
  } state_t;

  state_t            state, state_n;
  logic [15:0]       len, idx;
  logic [1:0]        bcnt;
  logic [31:0]       word, sum, vsum;
  logic [WCNT_W-1:0] wcnt;
  logic              xfer;
  logic [15:0]       len_full;
  logic              idx_last;

  assign xfer     = bus.in_valid & bus.in_ready;
  assign len_full = {bus.in_data, len[7:0]};
  assign idx_last = (idx + 16'd1) == len;

  // Outputs are decodes of the state register plus the idx/word registers
  assign bus.in_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign bus.ram_we   = (state == WRITE);
  assign bus.ram_a    = {14'd0, idx, 2'b00};
  assign bus.ram_wd   = word;
  assign cpu_resetn   = (state == DONE);
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign busy         = !((state == IDLE) || (state == DONE) || (state == ERROR));

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_n = LEN0;
      LEN0:  if (xfer) state_n = LEN1;
      LEN1: begin
        if (xfer) begin
          if (len_full == 16'd0)                   state_n = DONE;
          else if (len_full > 16'(DEPTH_WORDS))    state_n = ERROR;
          else                                     state_n = DATA;
        end
      end
      DATA:  if (xfer && (bcnt == 2'd3)) state_n = WRITE;
      WRITE: state_n = idx_last ? VADDR : DATA;
      VADDR: state_n = VWAIT;
      VWAIT: if (wcnt == WCNT_W'(RD_LATENCY - 1)) state_n = VSAMP;
      VSAMP: state_n = idx_last ? CHECK : VADDR;
      CHECK: state_n = (vsum == sum) ? DONE : ERROR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // idx/word are reset too since they drive ram_a/ram_wd directly
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx  <= '0;
      bcnt <= '0;
      wcnt <= '0;
      word <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            idx  <= '0;
            bcnt <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            word[{bcnt, 3'b000} +: 8] <= bus.in_data;
            bcnt                      <= bcnt + 2'd1;
          end
        end
        WRITE: idx  <= idx_last ? 16'd0 : idx + 16'd1;
        VADDR: wcnt <= '0;
        VWAIT: wcnt <= wcnt + WCNT_W'(1);
        VSAMP: idx  <= idx + 16'd1;
        default: ;
      endcase
    end
  end

  // Length and checksums are re-initialised by every load, so no reset
  always_ff @(posedge clk) begin
    case (state)
      IDLE, DONE, ERROR: if (start) sum <= '0;
      LEN0:  if (xfer) len[7:0]  <= bus.in_data;
      LEN1:  if (xfer) len[15:8] <= bus.in_data;
      WRITE: begin
        sum <= sum + word;
        if (idx_last) vsum <= '0;
      end
      VSAMP: vsum <= vsum + bus.ram_rd;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: RAM model with read-bit injection and a
// stream-level reference model of writes, byte consumption and final status.
module tb_ram_loader;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic cpu_resetn, busy, done, error;

  ram_loader_if bus ();

  ram_loader #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .bus(bus),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nbytes = 0;
  bit flip_en = 1'b0;
  logic [31:0] mem [0:31];
  logic [31:0] words [0:63];
  logic [63:0] wq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM registers read data; optional bit-0 flip on word 1 reads
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_a[6:2]] <= bus.ram_wd;
    bus.ram_rd <= mem[bus.ram_a[6:2]] ^
                  {31'd0, flip_en && (bus.ram_a == 32'd4) && !bus.ram_we};
  end

  always @(negedge clk) begin
    if (bus.ram_we) wq.push_back({bus.ram_a, bus.ram_wd});
    if (bus.in_valid && bus.in_ready) nbytes++;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, input string tag);
    bit taken = 1'b0;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(5, 1)) begin @(posedge clk); #1; end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 200 && !taken; n++) begin
      @(negedge clk);
      taken = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!taken) chk({tag, "_byte_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_ram_we"}, bus.ram_we, 0);
    chk({tag, "_ram_a"}, bus.ram_a, 0);
    chk({tag, "_ram_wd"}, bus.ram_wd, 0);
    chk({tag, "_cpu_resetn"}, cpu_resetn, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  // Full load of words[0:len-1] followed by model comparison
  task automatic do_load(input int len, input bit gaps, input bit flip, input string tag);
    int  b0 = nbytes;
    bit  len_ok = (len >= 1) && (len <= DEPTH);
    bit  exp_err;
    int  exp_writes;
    logic [31:0] sum_w, sum_r;
    bit  fin = 1'b0;
    wq.delete();
    flip_en = flip;
    pulse_start();
    send_byte(8'(len), gaps, tag);
    send_byte(8'(len >> 8), gaps, tag);
    if (len_ok)
      for (int i = 0; i < len; i++)
        for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], gaps, tag);
    for (int n = 0; n < 500 && !fin; n++) begin
      fin = done || error;
      if (!fin) begin @(posedge clk); #1; end
    end
    if (!fin) chk({tag, "_finish_timeout"}, 64'd0, 64'd1);

    sum_w = 32'd0;
    sum_r = 32'd0;
    for (int i = 0; i < len && len_ok; i++) begin
      sum_w += words[i];
      sum_r += (flip && i == 1) ? (words[i] ^ 32'd1) : words[i];
    end
    exp_err    = (len > DEPTH) || (sum_w != sum_r);
    exp_writes = len_ok ? len : 0;

    chk({tag, "_done"}, done, !exp_err);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_cpu_resetn"}, cpu_resetn, !exp_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bytes"}, nbytes - b0, 2 + 4 * exp_writes);
    chk({tag, "_nwrites"}, wq.size(), exp_writes);
    for (int i = 0; i < exp_writes && i < wq.size(); i++)
      chk({tag, "_write"}, wq[i], {32'(i * 4), words[i]});
    flip_en = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [0:10];
    int b0;
    prog = '{32'h00000293, 32'h00000313, 32'h00100393, 32'h0ff00e13,
             32'h00138393, 32'hffc39ee3, 32'h00134313, 32'h0062a023,
             32'h00000393, 32'h00000013, 32'hfd9ff06f};
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    #12;
    reset_checks("por");
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) words[i] = prog[i];
    do_load(11, 1'b0, 1'b0, "toggle");

    do_load(0, 1'b0, 1'b0, "len0");

    do_load(33, 1'b0, 1'b0, "len33");
    b0 = nbytes;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5a;
    repeat (5) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    chk("len33_no_take", nbytes - b0, 0);
    chk("len33_in_ready", bus.in_ready, 0);

    for (int i = 0; i < 2; i++) words[i] = $urandom;
    do_load(2, 1'b0, 1'b1, "vfail");

    for (int i = 0; i < 3; i++) words[i] = $urandom;
    do_load(3, 1'b0, 1'b0, "nogap");
    do_load(3, 1'b1, 1'b0, "gaps");

    for (int r = 0; r < 3; r++) begin
      int l = $urandom_range(DEPTH, 1);
      for (int i = 0; i < l; i++) words[i] = $urandom;
      do_load(l, r[0], 1'b0, "rand");
    end

    // Abort mid-stream: 6 data bytes, ignored start, then async reset
    wq.delete();
    pulse_start();
    send_byte(8'd2, 1'b0, "abort");
    send_byte(8'd0, 1'b0, "abort");
    for (int k = 0; k < 6; k++) send_byte(8'($urandom), 1'b0, "abort");
    pulse_start();
    chk("abort_start_ignored_busy", busy, 1);
    chk("abort_start_ignored_ready", bus.in_ready, 1);
    chk("abort_first_word", wq.size(), 1);
    @(posedge clk); #1 resetn = 1'b0;
    #2;
    reset_checks("abort_rst");
    @(posedge clk); #1 resetn = 1'b1;
    words[0] = $urandom;
    do_load(1, 1'b0, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
